// File: rtl/odd_even_sorter.sv
// Odd-even transposition sorter: one compare-exchange phase per clock over N unsigned W-bit elements.
// Optional macro SORTER_EARLY_EXIT_EN stops after an even/odd phase pair with no swaps.
module odd_even_sorter #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*W-1:0]             in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*W-1:0]             out_data,
  output logic [$clog2(N+1)-1:0]     phases
);

  localparam int unsigned PW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [N-1:0][W-1:0]    elem_q, elem_d, exch_c;
  logic [PW-1:0]          phases_q, phases_d;
  logic                   last_phase_c;
`ifdef SORTER_EARLY_EXIT_EN
  logic                   zero_prev_q, zero_prev_d;
  logic                   any_swap_c;
`endif

  // One transposition phase; parity of the phase count picks even or odd pairs
  always_comb begin
    exch_c = elem_q;
`ifdef SORTER_EARLY_EXIT_EN
    any_swap_c = 1'b0;
`endif
    for (int unsigned i = 0; i + 1 < N; i++) begin
      if ((i[0] == phases_q[0]) && (elem_q[i] > elem_q[i+1])) begin
        exch_c[i]   = elem_q[i+1];
        exch_c[i+1] = elem_q[i];
`ifdef SORTER_EARLY_EXIT_EN
        any_swap_c  = 1'b1;
`endif
      end
    end
  end

`ifdef SORTER_EARLY_EXIT_EN
  assign last_phase_c = (phases_q == PW'(N - 1)) || (zero_prev_q && !any_swap_c);
`else
  assign last_phase_c = (phases_q == PW'(N - 1));
`endif

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    phases_d    = phases_q;
`ifdef SORTER_EARLY_EXIT_EN
    zero_prev_d = zero_prev_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          elem_d      = in_data;
          phases_d    = '0;
`ifdef SORTER_EARLY_EXIT_EN
          zero_prev_d = 1'b0;
`endif
          state_d     = SORT;
        end
      end
      SORT: begin
        elem_d = exch_c;
        if (phases_q != PW'(N)) begin
          phases_d = phases_q + PW'(1);
        end
`ifdef SORTER_EARLY_EXIT_EN
        zero_prev_d = !any_swap_c;
`endif
        if (last_phase_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      phases_q    <= '0;
`ifdef SORTER_EARLY_EXIT_EN
      zero_prev_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phases_q    <= phases_d;
`ifdef SORTER_EARLY_EXIT_EN
      zero_prev_q <= zero_prev_d;
`endif
    end
  end

  // Handshake outputs decode the state register; accept is blocked while reset is held
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_data  = elem_q;
  assign phases    = phases_q;

endmodule

// File: tb/tb_odd_even_sorter.sv
// Directed bench for odd_even_sorter (N=8, W=8) with hand-computed sorted vectors.
module tb_odd_even_sorter;

  localparam int unsigned N = 8;
  localparam int unsigned W = 8;

`ifdef SORTER_EARLY_EXIT_EN
  localparam int SORTED_LAT = 2;
  localparam int MIXED_LAT  = 7;
`else
  localparam int SORTED_LAT = 8;
  localparam int MIXED_LAT  = 8;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N*W-1:0]   out_data;
  logic [3:0]       phases;

  int checks = 0;
  int errors = 0;

  odd_even_sorter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .phases    (phases)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until out_valid, bounded
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [63:0] vec, input logic [63:0] exp,
                         input int lat_exp);
    int lat;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_data   = vec;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_phases"}, 64'(phases), 64'(lat_exp));
    out_ready = 1'b1;
    tick();
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;

    // Reset state
    #1;
    chk("rst_in_ready_pre", 64'(in_ready), 64'd0);
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_phases", 64'(phases), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Reversed, already sorted, duplicates
    run_vec("reverse", 64'h0001020304050607, 64'h0706050403020100, 8);
    run_vec("sorted",  64'h0706050403020100, 64'h0706050403020100, SORTED_LAT);
    run_vec("dups",    64'h01FF0005FF000505, 64'hFFFF050505010000, MIXED_LAT);

    // Output backpressure with a competing input offered
    in_data   = 64'h1122334455667788;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_data = 64'h0102030405060708;
    wait_out(lat);
    chk("bp_latency", 64'(lat), 64'd8);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_data_hold", out_data, 64'h8877665544332211);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_valid", 64'(out_valid), 64'd0);
    chk("bp_idle_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp_b_accepted", 64'(in_ready), 64'd0);
    chk("bp_b_phases0", 64'(phases), 64'd0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp_b_latency", 64'(lat), 64'd8);
    chk("bp_b_data", out_data, 64'h0807060504030201);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of SORT
    in_data  = 64'h0001020304050607;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_phases3", 64'(phases), 64'd3);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_phases", 64'(phases), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_post_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    chk("mid_no_pulse", 64'(seen), 64'd0);
    run_vec("after_rst", 64'h01FF0005FF000505, 64'hFFFF050505010000, MIXED_LAT);

    // Back-to-back with in_valid held and out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h0001020304050607;
    tick();
    in_data = 64'h0102030405060708;
    wait_out(lat);
    chk("b2b_1_latency", 64'(lat), 64'd8);
    chk("b2b_1_data", out_data, 64'h0706050403020100);
    tick();
    chk("b2b_gap_valid", 64'(out_valid), 64'd0);
    chk("b2b_gap_ready", 64'(in_ready), 64'd1);
    tick();
    chk("b2b_2_accepted", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("b2b_2_latency", 64'(lat), 64'd8);
    chk("b2b_2_data", out_data, 64'h0807060504030201);
    tick();
    chk("b2b_2_pulse_end", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/odd_even_sorter.md
ODD_EVEN_SORTER -- requirements
Module: odd_even_sorter

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning element count (even, >= 2).
REQ-002 The block SHALL have parameter W, default 8, meaning element width in bits (unsigned).
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  input vector offered.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a vector.
REQ-007 The block SHALL have port in_data  input  N*W  element i at bits [i*W +: W].
REQ-008 The block SHALL have port out_valid  output  1  sorted vector available.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts sorted vector.
REQ-010 The block SHALL have port out_data  output  N*W  sorted elements, same packing as in_data.
REQ-011 The block SHALL have port phases  output  $clog2(N+1)  compare-exchange phases used for the current/last vector.

Function
REQ-012 The block SHALL implement FSM states IDLE, SORT, DONE.
REQ-013 In IDLE, in_ready SHALL be 1; in_valid && in_ready at an edge SHALL load in_data into the N element registers, clear phases, and go to SORT.
REQ-014 In SORT, each edge SHALL perform one transposition phase on all disjoint pairs: even phase pairs (0,1),(2,3),...; odd phase pairs (1,2),(3,4),...,(N-3,N-2); first phase even, then alternating.
REQ-015 Each compare-exchange SHALL swap only when lower-index element > higher-index element (unsigned); equal values SHALL NOT swap.
REQ-016 phases SHALL increment by 1 per SORT edge and saturate at N.
REQ-017 After the N-th phase (macro absent), state SHALL go to DONE; out_valid SHALL be 1 exactly N cycles after the accepting edge.
REQ-018 In DONE, out_valid SHALL be 1 and out_data SHALL equal the element registers, held stable until out_ready is 1 at an edge.
REQ-019 out_valid && out_ready at an edge SHALL return to IDLE; in_ready SHALL be 1 the following cycle (no same-cycle accept).
REQ-020 in_ready SHALL be 0 in SORT and DONE; in_valid there SHALL be ignored and in_data SHALL NOT affect state.
REQ-021 out_data SHALL be ascending: element 0 smallest, element N-1 largest; the output SHALL be a permutation of the input (duplicates preserved).
REQ-022 out_valid SHALL be 0 in IDLE and SORT.

Reset
REQ-023 rst high at an edge SHALL force IDLE, all element registers 0, phases 0, out_valid 0, from any state including mid-SORT and DONE.
REQ-024 in_ready SHALL be 0 while rst is high and 1 from the first cycle after rst deasserts.
REQ-025 A vector in progress at reset SHALL be discarded without any out_valid pulse.

Configuration
REQ-026 Macro SORTER_EARLY_EXIT_EN SHALL enable early termination: when two consecutive phases (one even, one odd) perform zero swaps, state SHALL go to DONE after the second of them; minimum 2 phases.
REQ-027 With SORTER_EARLY_EXIT_EN defined, phases SHALL report the actual phase count (2..N) and out_valid latency SHALL equal phases cycles after acceptance.
REQ-028 Without SORTER_EARLY_EXIT_EN, exactly N phases SHALL always run and phases SHALL read N in DONE; no swap-detect logic SHALL be synthesised.

Verification
REQ-029 N=8,W=8, in_data elements 0..7 = 7,6,5,4,3,2,1,0, out_ready=1 -> out_data elements 0..7 = 0..7, out_valid 8 cycles after accept, phases=8.
REQ-030 Input already sorted 0..7 with SORTER_EARLY_EXIT_EN -> out_valid 2 cycles after accept, phases=2, out_data = input; without macro -> 8 cycles, phases=8.
REQ-031 Input 5,5,0,255,5,0,255,1 -> out_data 0,0,1,5,5,5,255,255.
REQ-032 out_ready held 0 for 5 cycles in DONE, in_valid=1 with different data -> out_valid and out_data stable, in_ready=0, second vector accepted only in the cycle after the out handshake.
REQ-033 rst pulsed 1 cycle at phase 3 of SORT -> out_valid stays 0, out_data all 0, in_ready=1 next cycle; subsequent vector sorts correctly.
REQ-034 Back-to-back: in_valid held 1 with two vectors, out_ready=1 -> two out_valid pulses, each with correctly sorted data, separated by the IDLE cycle.
